// File: rtl/splice_sub_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The master drives start and operands; the slave returns status and results.
interface splice_sub_if;
  logic       start;
  logic [3:0] a0;
  logic [3:0] a1;
  logic [3:0] b0;
  logic [3:0] b1;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic [7:0] mag;
  logic       neg;

  modport master (
    output start, a0, a1, b0, b1,
    input  busy, done, diff, mag, neg
  );

  modport slave (
    input  start, a0, a1, b0, b1,
    output busy, done, diff, mag, neg
  );
endinterface

// File: rtl/splice_sub.sv
// Nibble-serial 8-bit unsigned subtractor: A - B one 4-bit stage per cycle,
// then absolute magnitude, with a start/busy/done handshake.
module splice_sub (
  input logic         clk,
  input logic         rst_n,
  splice_sub_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StFix, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] diff_q, diff_d;
  logic [7:0] mag_q, mag_d;
  logic       neg_q, neg_d;
  logic       c0_q, c0_d;
  logic [4:0] s0, s1;

  // Subtraction as addition of the inverted subtrahend; the +1 enters at the low stage.
  always_comb begin
    s0 = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + 5'd1;
    s1 = {1'b0, a_q[7:4]} + {1'b0, ~b_q[7:4]} + {4'd0, c0_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    c0_d    = c0_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = {bus.a1, bus.a0};
          b_d     = {bus.b1, bus.b0};
          state_d = StLo;
        end
      end
      StLo: begin
        diff_d[3:0] = s0[3:0];
        c0_d        = s0[4];
        state_d     = StHi;
      end
      StHi: begin
        diff_d[7:4] = s1[3:0];
        // No carry out of the top stage means a borrow, i.e. A < B.
        neg_d       = ~s1[4];
        state_d     = StFix;
      end
      StFix: begin
        mag_d   = neg_q ? (~diff_q + 8'd1) : diff_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      diff_q  <= 8'd0;
      mag_q   <= 8'd0;
      neg_q   <= 1'b0;
      c0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      c0_q    <= c0_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.diff = diff_q;
  assign bus.mag  = mag_q;
  assign bus.neg  = neg_q;

endmodule

// File: tb/tb_splice_sub.sv
// Scoreboard bench for splice_sub: a model process predicts results and done cycles
// at each accepted start; a monitor pops and compares whenever done is seen.
module tb_splice_sub;

  logic clk;
  logic rst_n;

  splice_sub_if bus ();

  splice_sub u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         done_cyc;
    logic [7:0] diff;
    logic [7:0] mag;
    logic       neg;
  } exp_t;

  exp_t exp_q[$];
  exp_t head;
  int   cyc       = 0;
  int   free_edge = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   ma, mb;
  logic [7:0] last_diff, last_mag;
  logic       last_neg;
  logic       prev_done;
  logic       exp_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an accepted start is any start seen while the block is idle.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        free_edge = 0;
      end else begin
        cyc++;
        if (bus.start === 1'b1 && cyc >= free_edge) begin
          exp_t e;
          ma = int'({bus.a1, bus.a0});
          mb = int'({bus.b1, bus.b0});
          e.done_cyc = cyc + 3;
          e.diff     = 8'((ma - mb + 256) % 256);
          e.neg      = (ma < mb);
          e.mag      = e.neg ? 8'(mb - ma) : 8'(ma - mb);
          exp_q.push_back(e);
          free_edge  = cyc + 5;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    last_diff = 8'd0;
    last_mag  = 8'd0;
    last_neg  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs", {bus.busy, bus.done, bus.diff, bus.mag, bus.neg}, 32'd0);
        last_diff = 8'd0;
        last_mag  = 8'd0;
        last_neg  = 1'b0;
        prev_done = 1'b0;
      end else begin
        exp_busy = (cyc < free_edge - 1);
        check("busy", bus.busy, exp_busy);
        if (bus.done === 1'b1) begin
          check("done_not_consecutive", prev_done, 1'b0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
          end else begin
            head = exp_q.pop_front();
            check("done_cycle", cyc, head.done_cyc);
            check("diff", bus.diff, head.diff);
            check("mag", bus.mag, head.mag);
            check("neg", bus.neg, head.neg);
            last_diff = head.diff;
            last_mag  = head.mag;
            last_neg  = head.neg;
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_done at cycle %0d: got done=0, expected done at cycle %0d",
                   cyc, exp_q[0].done_cyc);
          void'(exp_q.pop_front());
        end
        if (!exp_busy) begin
          check("hold_results", {bus.diff, bus.mag, bus.neg}, {last_diff, last_mag, last_neg});
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic scramble();
    {bus.a1, bus.a0, bus.b1, bus.b0} = 16'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && cyc >= free_edge - 1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout at cycle %0d: got still busy, expected idle", cyc);
      exp_q.delete();
    end
  endtask

  // One operation; operands change after acceptance, optionally with a stray start pulse.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input bit pulse);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    {bus.a1, bus.a0} = a;
    {bus.b1, bus.b0} = b;
    @(posedge clk);
    #1;
    bus.start = pulse;
    scramble();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    wait_idle();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a0    = 4'd0;
    bus.a1    = 4'd0;
    bus.b0    = 4'd0;
    bus.b1    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    op(8'h35, 8'h12, 1'b0);
    op(8'h12, 8'h35, 1'b0);
    op(8'h30, 8'h01, 1'b0);
    op(8'h7F, 8'h7F, 1'b0);
    op(8'h00, 8'hFF, 1'b0);
    op(8'h5A, 8'hC3, 1'b1);

    // Start held high: operations every 5 cycles, operands changing every cycle.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    scramble();
    repeat (24) begin
      @(posedge clk);
      #1;
      scramble();
    end
    bus.start = 1'b0;
    wait_idle();

    // Reset while the high stage is in flight.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    {bus.a1, bus.a0} = 8'hA7;
    {bus.b1, bus.b0} = 8'h3C;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op(8'h80, 8'h01, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no completion, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
